program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Boot-time stage directly upstream of the 8-bit memory unit.
- Receives a framed program image as a byte stream (valid/ready) and writes it into memory through the memory's address/data/write interface.
- Holds the processor in reset until a frame with a correct checksum has been fully written.
- Top level muxes memory address/data/write: loader drives them while cpu_reset=1, processor drives them otherwise.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, data/byte width.
- START_ADDR, 8'h00, address of the first payload byte.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1024, inter-byte timeout (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept a byte.
- mem_addr  out  ADDR_W  memory write address.
- mem_data  out  DATA_W  memory write data.
- mem_write  out  1  one-cycle write strobe.
- cpu_reset  out  1  processor hold-in-reset.
- busy  out  1  frame in progress (LEN/DATA/CHK).
- done  out  1  last frame loaded successfully.
- error  out  1  last frame failed.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high, named reset.
- Reset values:
  - state=IDLE, rx_ready=0 (rises the cycle after reset deasserts).
  - mem_addr=START_ADDR, mem_data=0, mem_write=0.
  - cpu_reset=1, busy=0, done=0, error=0.
  - Byte counter = 0, checksum = 0.
- Handshake: a byte transfers on a rising edge with rx_valid&rx_ready. rx_ready=1 in every state except during reset. The sender may hold rx_valid indefinitely; the loader never drops an accepted byte.
- Frame format: SYNC_BYTE, LEN (0 means 256), LEN payload bytes, CHK.
  - CHK = 8-bit modulo-256 sum of the payload bytes.
- States:
  - IDLE: non-sync bytes are discarded. Sync -> LEN, with busy=1, cpu_reset=1, done=0, error=0, checksum=0, mem_addr=START_ADDR.
  - LEN: latch count (0 -> 256, 9-bit counter) -> DATA.
  - DATA: each accepted byte is registered to mem_data/mem_addr. mem_write pulses high exactly one cycle, on the cycle after acceptance. mem_addr then increments, wrapping modulo 2^ADDR_W (START_ADDR=8'hFF, LEN=2 writes FF then 00). Checksum accumulates. Last byte -> CHK.
  - CHK: byte equals checksum -> DONE, with done=1, busy=0, cpu_reset=0 the cycle after acceptance. Mismatch -> ERR, with error=1, busy=0, cpu_reset stays 1.
  - DONE / ERR: non-sync bytes are ignored. Sync restarts the frame (-> LEN) and reasserts cpu_reset in the same edge.
- Back-to-back payload bytes on consecutive cycles are supported: one write per cycle, no stalls.
- A sync value inside LEN/DATA/CHK is ordinary data and is not a restart.
- Reset mid-frame: immediate return to reset values. Memory contents are not cleared; the partial image remains.
- mem_write never asserts outside DATA-state acceptances.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- When defined:
  - A counter clears on every accepted byte and increments each cycle in LEN/DATA/CHK.
  - Reaching TIMEOUT_CYCLES -> ERR (error=1, cpu_reset=1).
- When undefined:
  - No counter exists; the loader waits indefinitely mid-frame.
  - TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package/defines file holds:
  - State encoding constants: IDLE, LEN, DATA, CHK, DONE, ERR.
  - Default SYNC_BYTE.
  - Address/data width constants, kept consistent with the existing defines.v used by processor and memory.
- One natural sub-module: loader_checksum (8-bit accumulator with clear and add-enable), reusable for future stream checks.
- FSM, address counter and timeout stay in program_loader.

Test Plan:
- Reset, then frame A5 03 11 22 33 66 -> writes 11@00, 22@01, 33@02, one cycle each; done=1, cpu_reset=0, error=0.
- Bytes 00 FF before A5 02 AA 55 FF -> leading bytes ignored (no writes); AA@00, 55@01; done=1.
- A5 01 10 11 -> one write 10@00; error=1, cpu_reset stays 1. Then A5 01 10 10 -> done=1, error=0.
- START_ADDR=FF, frame A5 02 01 02 03 -> writes 01@FF, 02@00 (wrap); done=1.
- Reset asserted after the 2nd payload byte of a LEN=4 frame -> all outputs at reset values immediately, no further writes. A new full frame then loads correctly.
- LOADER_TIMEOUT_EN with TIMEOUT_CYCLES=16: A5 04 01, then idle 16 cycles -> error=1, cpu_reset=1. Without the macro, the same stimulus leaves busy=1 and error=0.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared constants and state encoding for the boot-time program loader.
package program_loader_pkg;

   // Widths track the processor/memory address and data buses.
   localparam int unsigned DefaultAddrW    = 8;
   localparam int unsigned DefaultDataW    = 8;
   localparam logic [7:0]  DefaultSyncByte = 8'hA5;

   typedef enum logic [2:0] {
      StIdle,
      StLen,
      StData,
      StChk,
      StDone,
      StErr
   } state_e;

   // True while a frame is being received (LEN/DATA/CHK).
   function automatic logic is_frame_state(input state_e s);
      return (s == StLen) || (s == StData) || (s == StChk);
   endfunction

endpackage

// File: rtl/loader_checksum.sv
// Modulo-2^W byte accumulator with synchronous clear and add-enable.
module loader_checksum #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         add_en,
   input  logic [W-1:0] data,
   output logic [W-1:0] sum
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum <= '0;
      end else if (clear) begin
         sum <= '0;
      end else if (add_en) begin
         sum <= sum + data;
      end
   end

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader: writes SYNC/LEN/payload/CHK frames into memory and holds the CPU
// in reset until a frame checks out. Inter-byte timeout is compiled in with LOADER_TIMEOUT_EN.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int unsigned          ADDR_W         = DefaultAddrW,
   parameter int unsigned          DATA_W         = DefaultDataW,
   parameter logic [ADDR_W-1:0]    START_ADDR     = '0,
   parameter logic [DATA_W-1:0]    SYNC_BYTE      = DefaultSyncByte,
   parameter int unsigned          TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_write,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              error
);

   // One extra bit so LEN=0 can stand for 2^DATA_W bytes.
   localparam int unsigned CntW = DATA_W + 1;

   state_e            state_q;
   logic [CntW-1:0]   cnt_q;
   logic              rx_ready_q;
   logic              mem_write_q;
   logic              cpu_reset_q;
   logic              busy_q;
   logic              done_q;
   logic              error_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_data_q;

   logic              accept;
   logic              start;
   logic              sum_add;
   logic [DATA_W-1:0] sum;

   assign accept  = rx_valid & rx_ready_q;
   // A sync byte only restarts outside a frame; inside one it is plain data.
   assign start   = accept && (rx_data == SYNC_BYTE) && !is_frame_state(state_q);
   assign sum_add = accept && (state_q == StData);

   loader_checksum #(
      .W (DATA_W)
   ) u_checksum (
      .clk    (clk),
      .reset  (reset),
      .clear  (start),
      .add_en (sum_add),
      .data   (rx_data),
      .sum    (sum)
   );

`ifdef LOADER_TIMEOUT_EN
   localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
   logic [ToW-1:0] to_cnt_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         rx_ready_q  <= 1'b0;
         mem_write_q <= 1'b0;
         cpu_reset_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         mem_addr_q  <= START_ADDR;
         mem_data_q  <= '0;
`ifdef LOADER_TIMEOUT_EN
         to_cnt_q    <= '0;
`endif
      end else begin
         rx_ready_q  <= 1'b1;
         mem_write_q <= 1'b0;
         // Advance the address once the write it carried has been presented.
         if (mem_write_q) begin
            mem_addr_q <= mem_addr_q + ADDR_W'(1);
         end
`ifdef LOADER_TIMEOUT_EN
         if (accept) begin
            to_cnt_q <= '0;
         end
`endif
         if (start) begin
            state_q     <= StLen;
            busy_q      <= 1'b1;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            mem_addr_q  <= START_ADDR;
         end else if (accept) begin
            case (state_q)
               StLen: begin
                  cnt_q   <= (rx_data == '0) ? {1'b1, {DATA_W{1'b0}}} : {1'b0, rx_data};
                  state_q <= StData;
               end
               StData: begin
                  mem_data_q  <= rx_data;
                  mem_write_q <= 1'b1;
                  cnt_q       <= cnt_q - CntW'(1);
                  if (cnt_q == CntW'(1)) begin
                     state_q <= StChk;
                  end
               end
               StChk: begin
                  busy_q <= 1'b0;
                  if (rx_data == sum) begin
                     state_q     <= StDone;
                     done_q      <= 1'b1;
                     cpu_reset_q <= 1'b0;
                  end else begin
                     state_q <= StErr;
                     error_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
`ifdef LOADER_TIMEOUT_EN
         else if (busy_q) begin
            if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
               state_q     <= StErr;
               error_q     <= 1'b1;
               busy_q      <= 1'b0;
               cpu_reset_q <= 1'b1;
               to_cnt_q    <= '0;
            end else begin
               to_cnt_q <= to_cnt_q + ToW'(1);
            end
         end
`endif
      end
   end

   assign rx_ready  = rx_ready_q;
   assign mem_addr  = mem_addr_q;
   assign mem_data  = mem_data_q;
   assign mem_write = mem_write_q;
   assign cpu_reset = cpu_reset_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench: two loaders (START_ADDR 00 and FF) fed the same stream, checked against
// a frame-level model of expected writes and pass/fail outcome.
module tb_program_loader;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_valid;

   logic       rx_ready  [2];
   logic [7:0] mem_addr  [2];
   logic [7:0] mem_data  [2];
   logic       mem_write [2];
   logic       cpu_reset [2];
   logic       busy      [2];
   logic       done      [2];
   logic       error     [2];

   always #5 clk = ~clk;

   program_loader #(
      .ADDR_W(8), .DATA_W(8), .START_ADDR(8'h00), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)
   ) u_dut0 (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready[0]), .mem_addr(mem_addr[0]), .mem_data(mem_data[0]),
      .mem_write(mem_write[0]), .cpu_reset(cpu_reset[0]), .busy(busy[0]),
      .done(done[0]), .error(error[0])
   );

   program_loader #(
      .ADDR_W(8), .DATA_W(8), .START_ADDR(8'hFF), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)
   ) u_dut1 (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready[1]), .mem_addr(mem_addr[1]), .mem_data(mem_data[1]),
      .mem_write(mem_write[1]), .cpu_reset(cpu_reset[1]), .busy(busy[1]),
      .done(done[1]), .error(error[1])
   );

   typedef struct packed {
      int         cyc;
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;

   typedef struct packed {
      logic [1:0]      npre;
      logic [1:0][7:0] pre;
      logic [2:0]      len;
      logic [3:0][7:0] pay;
      logic [7:0]      chk;
      logic            ok;
   } vec_t;

   wr_t        wq0[$];
   wr_t        wq1[$];
   logic [7:0] pay_q[$];
   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;
   bit         gaps = 1'b0;
   vec_t       vecs[8];

   always @(posedge clk) cyc <= cyc + 1;

   // Write monitor: every cycle with mem_write high is one recorded write.
   always @(negedge clk) begin
      wr_t w;
      if (mem_write[0] === 1'b1) begin
         w.cyc = cyc; w.a = mem_addr[0]; w.d = mem_data[0];
         wq0.push_back(w);
      end
      if (mem_write[1] === 1'b1) begin
         w.cyc = cyc; w.a = mem_addr[1]; w.d = mem_data[1];
         wq1.push_back(w);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      if (gaps && $urandom_range(0, 3) == 0) idle(1 + $urandom_range(0, 2));
      rx_data  = b;
      rx_valid = 1'b1;
      while (rx_ready[0] !== 1'b1 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 20) begin
         n_tests++;
         n_fail++;
         $display("FAIL rx_ready wait: got 0 expected 1 within 20 cycles");
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic check_reset_vals(input string tag);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s dut%0d rx_ready", tag, k), 32'(rx_ready[k]), 32'd0);
         check($sformatf("%s dut%0d mem_addr", tag, k), 32'(mem_addr[k]),
               (k == 0) ? 32'h00 : 32'hFF);
         check($sformatf("%s dut%0d mem_data", tag, k), 32'(mem_data[k]), 32'd0);
         check($sformatf("%s dut%0d mem_write", tag, k), 32'(mem_write[k]), 32'd0);
         check($sformatf("%s dut%0d cpu_reset", tag, k), 32'(cpu_reset[k]), 32'd1);
         check($sformatf("%s dut%0d busy", tag, k), 32'(busy[k]), 32'd0);
         check($sformatf("%s dut%0d done", tag, k), 32'(done[k]), 32'd0);
         check($sformatf("%s dut%0d error", tag, k), 32'(error[k]), 32'd0);
      end
   endtask

   task automatic check_writes(input string tag, input bit chk_cyc);
      wr_t        w;
      wr_t        w0;
      logic [7:0] base;
      int         nw;
      for (int k = 0; k < 2; k++) begin
         base = (k == 0) ? 8'h00 : 8'hFF;
         nw   = (k == 0) ? wq0.size() : wq1.size();
         check($sformatf("%s dut%0d write count", tag, k), 32'(nw), 32'(pay_q.size()));
         if (nw == pay_q.size()) begin
            for (int i = 0; i < nw; i++) begin
               w = (k == 0) ? wq0[i] : wq1[i];
               if (i == 0) w0 = w;
               check($sformatf("%s dut%0d wr%0d addr", tag, k, i), 32'(w.a),
                     32'(8'(base + 8'(i))));
               check($sformatf("%s dut%0d wr%0d data", tag, k, i), 32'(w.d), 32'(pay_q[i]));
               if (chk_cyc)
                  check($sformatf("%s dut%0d wr%0d cycle", tag, k, i), 32'(w.cyc - w0.cyc),
                        32'(i));
            end
         end
      end
   endtask

   // Sends SYNC, LEN, pay_q and CHK; expects pay_q written from each DUT's base address.
   task automatic run_frame(input string tag, input logic [7:0] len_byte, input logic [7:0] chk,
                            input bit exp_ok);
      send_byte(8'hA5);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s dut%0d busy after sync", tag, k), 32'(busy[k]), 32'd1);
         check($sformatf("%s dut%0d cpu_reset after sync", tag, k), 32'(cpu_reset[k]), 32'd1);
         check($sformatf("%s dut%0d done after sync", tag, k), 32'(done[k]), 32'd0);
         check($sformatf("%s dut%0d error after sync", tag, k), 32'(error[k]), 32'd0);
      end
      send_byte(len_byte);
      foreach (pay_q[i]) send_byte(pay_q[i]);
      send_byte(chk);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s dut%0d done", tag, k), 32'(done[k]), 32'(exp_ok));
         check($sformatf("%s dut%0d error", tag, k), 32'(error[k]), 32'(!exp_ok));
         check($sformatf("%s dut%0d cpu_reset", tag, k), 32'(cpu_reset[k]), 32'(!exp_ok));
         check($sformatf("%s dut%0d busy", tag, k), 32'(busy[k]), 32'd0);
      end
      idle(2);
      check_writes(tag, !gaps);
   endtask

   initial begin
      //            npre pre      len   pay           chk    ok
      vecs[0] = '{2'd0, 16'h0000, 3'd3, 32'h00332211, 8'h66, 1'b1};
      vecs[1] = '{2'd2, 16'hFF00, 3'd2, 32'h000055AA, 8'hFF, 1'b1};
      vecs[2] = '{2'd0, 16'h0000, 3'd1, 32'h00000010, 8'h11, 1'b0};
      vecs[3] = '{2'd0, 16'h0000, 3'd1, 32'h00000010, 8'h10, 1'b1};
      vecs[4] = '{2'd0, 16'h0000, 3'd2, 32'h00000201, 8'h03, 1'b1};
      vecs[5] = '{2'd1, 16'h0011, 3'd3, 32'h0000A5A5, 8'h4A, 1'b1};
      vecs[6] = '{2'd0, 16'h0000, 3'd1, 32'h00000000, 8'hA5, 1'b0};
      vecs[7] = '{2'd2, 16'h5A00, 3'd4, 32'h04030201, 8'h0A, 1'b1};

      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      idle(2);
      check_reset_vals("reset");
      reset = 1'b0;
      check("dut0 rx_ready right after reset release", 32'(rx_ready[0]), 32'd0);
      idle(1);
      check("dut0 rx_ready one cycle after release", 32'(rx_ready[0]), 32'd1);
      check("dut1 rx_ready one cycle after release", 32'(rx_ready[1]), 32'd1);

      for (int v = 0; v < 8; v++) begin
         wq0.delete();
         wq1.delete();
         for (int p = 0; p < 4; p++)
            if (p < int'(vecs[v].npre)) send_byte(vecs[v].pre[p]);
         pay_q.delete();
         for (int i = 0; i < int'(vecs[v].len); i++) pay_q.push_back(vecs[v].pay[i]);
         run_frame($sformatf("vec%0d", v), {5'b0, vecs[v].len}, vecs[v].chk, vecs[v].ok);
      end

      // Reset in the middle of a LEN=4 frame after two payload bytes.
      wq0.delete();
      wq1.delete();
      pay_q = '{8'h01, 8'h02};
      send_byte(8'hA5);
      send_byte(8'h04);
      send_byte(8'h01);
      send_byte(8'h02);
      idle(1);
      reset = 1'b1;
      #1;
      check_reset_vals("midreset");
      idle(3);
      check_writes("midreset", 1'b1);
      reset = 1'b0;
      check("midreset rx_ready after release", 32'(rx_ready[0]), 32'd0);
      idle(1);
      wq0.delete();
      wq1.delete();
      pay_q = '{8'h11, 8'h22, 8'h33};
      run_frame("after midreset", 8'h03, 8'h66, 1'b1);

      // Stalled frame: error after the timeout when enabled, otherwise wait forever.
      send_byte(8'hA5);
      send_byte(8'h04);
      send_byte(8'h01);
      idle(20);
      for (int k = 0; k < 2; k++) begin
`ifdef LOADER_TIMEOUT_EN
         check($sformatf("stall dut%0d error", k), 32'(error[k]), 32'd1);
         check($sformatf("stall dut%0d busy", k), 32'(busy[k]), 32'd0);
`else
         check($sformatf("stall dut%0d error", k), 32'(error[k]), 32'd0);
         check($sformatf("stall dut%0d busy", k), 32'(busy[k]), 32'd1);
`endif
         check($sformatf("stall dut%0d cpu_reset", k), 32'(cpu_reset[k]), 32'd1);
      end
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      idle(1);

      // Random frames against the frame-level model; frame 7 uses LEN=0 (256 bytes).
      for (int f = 0; f < 20; f++) begin
         int         len;
         int         njunk;
         logic [7:0] s;
         logic [7:0] b;
         logic [7:0] chk;
         bit         ok;
         len   = (f == 7) ? 256 : int'($urandom_range(1, 12));
         gaps  = (f % 2 == 1);
         s     = 8'h00;
         pay_q.delete();
         for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            pay_q.push_back(b);
            s = s + b;
         end
         ok  = ($urandom_range(0, 3) != 0);
         chk = ok ? s : 8'(s + 8'($urandom_range(1, 255)));
         wq0.delete();
         wq1.delete();
         njunk = int'($urandom_range(0, 2));
         for (int j = 0; j < njunk; j++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            send_byte(b);
         end
         run_frame($sformatf("rand%0d", f), 8'(len), chk, ok);
      end
      gaps = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
